// File: rtl/j_sat_wbctl.sv
// Sequencer/arbiter sharing one combinational saturator between MAC writeback (req 0) and ALU SAT (req 1).
// Ready to wb_valid takes 2 cycles. Holds each result until wb_ack, and accepts no new request meanwhile.
// Optional sticky saturation status behind macro SAT_STATUS_EN.
module j_sat_wbctl #(
    parameter int RADDR_W = 5,
    parameter bit FAIR_RR = 1'b1
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [39:0]        req0_acc,
    input  logic [RADDR_W-1:0] req0_addr,
    input  logic               req0_sz32,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [31:0]        req1_data,
    input  logic [RADDR_W-1:0] req1_addr,
    input  logic               req1_sz32,
    output logic [31:0]        sat_d,
    output logic [7:0]         sat_accum,
    output logic               sat_szp,
    input  logic [31:0]        sat_q,
    output logic               wb_valid,
    output logic [31:0]        wb_data,
    output logic [RADDR_W-1:0] wb_addr,
    input  logic               wb_ack,
    output logic               busy
`ifdef SAT_STATUS_EN
    ,
    output logic               sat_flag,
    input  logic               sat_flag_clr
`endif
);

    typedef enum logic [1:0] {IDLE, DRIVE, WB} state_t;

    state_t             state;
    logic               rr_ptr;
    logic [RADDR_W-1:0] addr_q;
    logic               grant0;
    logic               grant1;

    // rr_ptr names the requester favoured on a tie; 0 favours req 0.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !reset) begin
            if (req0_valid && (!req1_valid || !FAIR_RR || !rr_ptr))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            addr_q    <= '0;
            sat_d     <= '0;
            sat_accum <= '0;
            sat_szp   <= 1'b0;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            wb_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        sat_d     <= req0_acc[31:0];
                        sat_accum <= req0_acc[39:32];
                        sat_szp   <= req0_sz32;
                        addr_q    <= req0_addr;
                        rr_ptr    <= 1'b1;
                        state     <= DRIVE;
                    end else if (grant1) begin
                        // Sign-extended guard bits make 32-bit saturation of an ALU value an identity.
                        sat_d     <= req1_data;
                        sat_accum <= {8{req1_data[31]}};
                        sat_szp   <= req1_sz32;
                        addr_q    <= req1_addr;
                        rr_ptr    <= 1'b0;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    wb_data  <= sat_q;
                    wb_addr  <= addr_q;
                    wb_valid <= 1'b1;
                    state    <= WB;
                end
                WB: begin
                    if (wb_ack) begin
                        wb_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SAT_STATUS_EN
    // A set in DRIVE takes priority over a coincident clear.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)
            sat_flag <= 1'b0;
        else if (state == DRIVE && sat_q != sat_d)
            sat_flag <= 1'b1;
        else if (sat_flag_clr)
            sat_flag <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_j_sat_wbctl.sv
// Bench for j_sat_wbctl: round-robin and fixed-priority instances driven in parallel from a vector table.
module tb_j_sat_wbctl;

    logic        sys_clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [39:0] req0_acc;
    logic [4:0]  req0_addr, req1_addr;
    logic        req0_sz32, req1_sz32;
    logic [31:0] req1_data;
    logic        wb_ack;

    logic        req0_ready, req1_ready, sat_szp, wb_valid, busy;
    logic [31:0] sat_d, sat_q, wb_data;
    logic [7:0]  sat_accum;
    logic [4:0]  wb_addr;

    logic        fx_req0_ready, fx_req1_ready, fx_sat_szp, fx_wb_valid, fx_busy;
    logic [31:0] fx_sat_d, fx_sat_q, fx_wb_data;
    logic [7:0]  fx_sat_accum;
    logic [4:0]  fx_wb_addr;

`ifdef SAT_STATUS_EN
    logic sat_flag, fx_sat_flag, sat_flag_clr;
    bit   clr_drive = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference saturator: 40-bit signed value clamped to signed 32 or signed 16 (sign-extended).
    function automatic logic [31:0] sat_model(input logic [7:0] hi, input logic [31:0] d, input logic szp);
        logic signed [39:0] v;
        v = {hi, d};
        if (szp) begin
            if (v > 40'sh007FFFFFFF) return 32'h7FFF_FFFF;
            if (v < -40'sh0080000000) return 32'h8000_0000;
            return d;
        end
        if (v > 40'sd32767) return 32'h0000_7FFF;
        if (v < -40'sd32768) return 32'hFFFF_8000;
        return d;
    endfunction

    assign sat_q    = sat_model(sat_accum, sat_d, sat_szp);
    assign fx_sat_q = sat_model(fx_sat_accum, fx_sat_d, fx_sat_szp);

    j_sat_wbctl #(.RADDR_W(5), .FAIR_RR(1'b1)) u_rr (
        .sys_clk(sys_clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_acc(req0_acc),
        .req0_addr(req0_addr), .req0_sz32(req0_sz32),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_addr(req1_addr), .req1_sz32(req1_sz32),
        .sat_d(sat_d), .sat_accum(sat_accum), .sat_szp(sat_szp), .sat_q(sat_q),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr), .wb_ack(wb_ack),
        .busy(busy)
`ifdef SAT_STATUS_EN
        , .sat_flag(sat_flag), .sat_flag_clr(sat_flag_clr)
`endif
    );

    j_sat_wbctl #(.RADDR_W(5), .FAIR_RR(1'b0)) u_fx (
        .sys_clk(sys_clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(fx_req0_ready), .req0_acc(req0_acc),
        .req0_addr(req0_addr), .req0_sz32(req0_sz32),
        .req1_valid(req1_valid), .req1_ready(fx_req1_ready), .req1_data(req1_data),
        .req1_addr(req1_addr), .req1_sz32(req1_sz32),
        .sat_d(fx_sat_d), .sat_accum(fx_sat_accum), .sat_szp(fx_sat_szp), .sat_q(fx_sat_q),
        .wb_valid(fx_wb_valid), .wb_data(fx_wb_data), .wb_addr(fx_wb_addr), .wb_ack(wb_ack),
        .busy(fx_busy)
`ifdef SAT_STATUS_EN
        , .sat_flag(fx_sat_flag), .sat_flag_clr(sat_flag_clr)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          v0, v1;
        logic [39:0] acc;
        logic [4:0]  a0;
        bit          s0;
        logic [31:0] data;
        logic [4:0]  a1;
        bit          s1;
        int          exp_g;
        logic [31:0] exp_data;
        logic [4:0]  exp_addr;
        int          ack_delay;
        bit          ack_early;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int lat;
        @(negedge sys_clk);
        req0_valid = v.v0; req0_acc = v.acc; req0_addr = v.a0; req0_sz32 = v.s0;
        req1_valid = v.v1; req1_data = v.data; req1_addr = v.a1; req1_sz32 = v.s1;
        wb_ack = v.ack_early;
        #1;
        chk("ready0", req0_ready, v.exp_g == 0);
        chk("ready1", req1_ready, v.exp_g == 1);
        chk("fx_ready0", fx_req0_ready, v.v0);
        e.data = v.exp_data;
        e.addr = v.exp_addr;
        sb.push_back(e);
        @(posedge sys_clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("busy_drive", busy, 1'b1);
        chk("wb_valid_drive", wb_valid, 1'b0);
        chk("sat_d", sat_d, v.exp_g == 0 ? v.acc[31:0] : v.data);
        chk("sat_accum", sat_accum, v.exp_g == 0 ? v.acc[39:32] : {8{v.data[31]}});
        chk("sat_szp", sat_szp, v.exp_g == 0 ? v.s0 : v.s1);
`ifdef SAT_STATUS_EN
        sat_flag_clr = clr_drive;
`endif
        lat = 1;
        @(posedge sys_clk); #1;
        lat++;
`ifdef SAT_STATUS_EN
        sat_flag_clr = 1'b0;
`endif
        while (!wb_valid && lat < 8) begin
            @(posedge sys_clk); #1;
            lat++;
        end
        chk("latency", lat, 2);
        if (wb_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk("wb_data", wb_data, e.data);
            chk("wb_addr", wb_addr, e.addr);
        end
        repeat (v.ack_delay) begin
            @(negedge sys_clk);
            chk("stall_hold", {wb_valid, wb_data, wb_addr, req0_ready, req1_ready},
                {1'b1, e.data, e.addr, 2'b00});
        end
        @(negedge sys_clk);
        wb_ack = 1'b1;
        @(posedge sys_clk); #1;
        wb_ack = 1'b0;
        chk("idle_after_ack", {busy, wb_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int wbcnt;
        vec_t rv;
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_acc = '0; req0_addr = '0; req0_sz32 = 0;
        req1_data = '0; req1_addr = '0; req1_sz32 = 0; wb_ack = 0;
`ifdef SAT_STATUS_EN
        sat_flag_clr = 1'b0;
`endif
        //          v0 v1 acc                 a0 s0 data           a1 s1 g  exp_data        addr dly early
        vecs[0] = '{1, 0, 40'h00_0001_2345, 5'd3,  0, 32'h0,          5'd0, 0, 0, 32'h0000_7FFF, 5'd3,  0, 0};
        vecs[1] = '{0, 1, 40'h0,            5'd0,  0, 32'h8000_0000,  5'd7, 1, 1, 32'h8000_0000, 5'd7,  0, 0};
        vecs[2] = '{1, 1, 40'hFF_FFFF_0000, 5'd1,  0, 32'h0000_1234,  5'd2, 0, 0, 32'hFFFF_8000, 5'd1,  0, 0};
        vecs[3] = '{1, 1, 40'hFF_FFFF_0000, 5'd1,  0, 32'h0000_1234,  5'd2, 0, 1, 32'h0000_1234, 5'd2,  0, 0};
        vecs[4] = '{1, 1, 40'hFF_FFFF_0000, 5'd1,  0, 32'h0000_1234,  5'd2, 0, 0, 32'hFFFF_8000, 5'd1,  0, 0};
        vecs[5] = '{1, 0, 40'h01_0000_0000, 5'd31, 1, 32'h0,          5'd0, 0, 0, 32'h7FFF_FFFF, 5'd31, 5, 0};
        vecs[6] = '{0, 1, 40'h0,            5'd0,  0, 32'h7FFF_0000,  5'd0, 0, 1, 32'h0000_7FFF, 5'd0,  0, 1};
        vecs[7] = '{1, 0, 40'hFF_8000_0000, 5'd9,  1, 32'h0,          5'd0, 0, 0, 32'h8000_0000, 5'd9,  2, 0};
        vecs[8] = '{0, 1, 40'h0,            5'd0,  0, 32'hFFFF_8000,  5'd4, 0, 1, 32'hFFFF_8000, 5'd4,  0, 0};
        vecs[9] = '{1, 0, 40'h00_0000_8000, 5'd10, 0, 32'h0,          5'd0, 0, 0, 32'h0000_7FFF, 5'd10, 0, 0};

        #1;
        chk("reset_outputs", {wb_valid, wb_data, wb_addr, sat_d, sat_accum, sat_szp, busy},
            {1'b0, 32'h0, 5'h0, 32'h0, 8'h0, 1'b0, 1'b0});
        req0_valid = 1'b1;
        #1;
        chk("reset_ready", {req0_ready, req1_ready}, 2'b00);
        req0_valid = 1'b0;
`ifdef SAT_STATUS_EN
        chk("flag_reset", sat_flag, 1'b0);
`endif
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

`ifdef SAT_STATUS_EN
        chk("flag_set", sat_flag, 1'b1);
        rv = '{0, 1, 40'h0, 5'd0, 0, 32'h0000_1234, 5'd6, 0, 1, 32'h0000_1234, 5'd6, 0, 0};
        run_vec(rv);
        chk("flag_sticky", sat_flag, 1'b1);
        @(negedge sys_clk); sat_flag_clr = 1'b1;
        @(posedge sys_clk); #1; sat_flag_clr = 1'b0;
        chk("flag_clr", sat_flag, 1'b0);
        clr_drive = 1'b1;
        rv = '{1, 0, 40'h00_0001_2345, 5'd8, 0, 32'h0, 5'd0, 0, 0, 32'h0000_7FFF, 5'd8, 0, 0};
        run_vec(rv);
        clr_drive = 1'b0;
        chk("flag_set_wins", sat_flag, 1'b1);
`endif

        // Reset while in DRIVE: pending result must vanish.
        @(negedge sys_clk);
        req0_valid = 1'b1; req0_acc = 40'h00_0000_0042; req0_addr = 5'd12; req0_sz32 = 1'b0;
        @(posedge sys_clk); #1;
        chk("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("midop_reset", {wb_valid, wb_data, wb_addr, sat_d, sat_accum, sat_szp, busy, req0_ready},
            {1'b0, 32'h0, 5'h0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0});
        req0_valid = 1'b0;
        @(negedge sys_clk);
        reset = 1'b0;
        wbcnt = 0;
        repeat (4) begin
            @(posedge sys_clk); #1;
            if (wb_valid) wbcnt++;
        end
        chk("no_wb_after_reset", wbcnt, 0);
        rv = '{1, 1, 40'h00_0000_0042, 5'd12, 0, 32'h0000_0055, 5'd13, 1, 0, 32'h0000_0042, 5'd12, 1, 0};
        run_vec(rv);
        rv = '{1, 1, 40'h00_0000_0042, 5'd12, 0, 32'h0000_0055, 5'd13, 1, 1, 32'h0000_0055, 5'd13, 0, 0};
        run_vec(rv);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
